// File: rtl/dpram_data_arbiter_pkg.sv
// Shared constants, widths and FSM encodings for the RAM data-port arbiter.
package dpram_data_arbiter_pkg;

  localparam int   ADDR_WIDTH_DEF = 32;
  localparam int   DATA_WIDTH_DEF = 32;
  localparam logic WRITE_ENABLE   = 1'b1;
  localparam logic ZERO           = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_ACK    = 2'd2
  } arb_state_t;

  function automatic logic other_master(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/dpram_data_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the master that was not granted last.
module rr_arb2
  import dpram_data_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_vld,
  output logic       grant_idx
);

  always_comb begin
    grant_vld = |req;
    grant_idx = ZERO;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = other_master(last_grant);
      default: grant_idx = ZERO;
    endcase
  end

endmodule

// File: rtl/dpram_data_arbiter.sv
// Shares the RAM data port between M0 (CPU LSU) and M1 (DMA): one transaction
// per IDLE->ACCESS->ACK pass, request-to-ack latency 2 cycles, non-owner waits.
module dpram_data_arbiter
  import dpram_data_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  arb_state_t            state;
  logic                  owner;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q;
  logic [DATA_WIDTH-1:0] m1_rdata_q;
  logic                  m0_ack_q;
  logic                  m1_ack_q;
  logic                  grant_vld;
  logic                  grant_idx;
  logic                  in_access;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_req_i, m0_req_i}),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ARB_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            owner   <= grant_idx;
            addr_q  <= grant_idx ? m1_addr_i  : m0_addr_i;
            we_q    <= grant_idx ? m1_we_i    : m0_we_i;
            wdata_q <= grant_idx ? m1_wdata_i : m0_wdata_i;
            state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // Captured on writes too; the RAM returns the pre-write word here.
          if (owner) begin
            m1_rdata_q <= ram_rdata_i;
            m1_ack_q   <= 1'b1;
          end else begin
            m0_rdata_q <= ram_rdata_i;
            m0_ack_q   <= 1'b1;
          end
          last_grant <= owner;
          state      <= ARB_ACK;
        end
        ARB_ACK: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // RAM strobes decode from state so reset kills a pending write immediately.
  assign in_access   = (state == ARB_ACCESS);
  assign ram_addr_o  = in_access ? addr_q  : '0;
  assign ram_wdata_o = in_access ? wdata_q : '0;
  assign ram_we_o    = in_access && (we_q == WRITE_ENABLE);

  assign busy_o     = (state != ARB_IDLE);
  assign owner_o    = owner;
  assign m0_ack_o   = m0_ack_q;
  assign m1_ack_o   = m1_ack_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;

endmodule

// File: tb/tb_dpram_data_arbiter.sv
// Directed bench for dpram_data_arbiter with a behavioural RAM on the data port.
module tb_dpram_data_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        m0_req_i, m0_we_i, m0_ack_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic        m1_req_i, m1_we_i, m1_ack_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        ram_we_o, busy_o, owner_o;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we_base;

  logic [31:0] mem [0:255];

  dpram_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_we_i     (m0_we_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_ack_o    (m0_ack_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_addr_i   (m1_addr_i),
    .m1_we_i     (m1_we_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_ack_o    (m1_ack_o),
    .m1_rdata_o  (m1_rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign ram_rdata_i = mem[ram_addr_o[9:2]];
  always @(posedge clk_i) if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
  always @(negedge clk_i) if (ram_we_o) we_cnt = we_cnt + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_we", ram_we_o, 0);
    rst_n_i = 1'b1;
    tick();

    // Reset landing in the middle of a write access
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h40; m0_wdata_i = 32'h5555AAAA;
    tick();
    chk("acc_busy", busy_o, 1);
    chk("acc_we", ram_we_o, 1);
    chk("acc_addr", ram_addr_o, 32'h40);
    rst_n_i = 1'b0;
    #1;
    chk("rst_we_drop", ram_we_o, 0);
    chk("rst_busy_drop", busy_o, 0);
    m0_req_i = 0; m0_we_i = 0;
    tick();
    chk("rst_no_ack", m0_ack_o, 0);
    rst_n_i = 1'b1;
    tick(); tick();
    chk("post_m0_ack", m0_ack_o, 0);
    chk("post_m1_ack", m1_ack_o, 0);
    chk("post_m0_rdata", m0_rdata_o, 0);
    chk("post_m1_rdata", m1_rdata_o, 0);
    chk("post_addr", ram_addr_o, 0);
    chk("post_wdata", ram_wdata_o, 0);
    chk("post_we", ram_we_o, 0);
    chk("post_busy", busy_o, 0);
    chk("post_owner", owner_o, 0);

    // M0 alone: write then read back
    we_base = we_cnt;
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h10; m0_wdata_i = 32'hDEADBEEF;
    tick();
    chk("wr_addr", ram_addr_o, 32'h10);
    chk("wr_wdata", ram_wdata_o, 32'hDEADBEEF);
    chk("wr_owner", owner_o, 0);
    chk("wr_ack_early", m0_ack_o, 0);
    tick();
    chk("wr_ack", m0_ack_o, 1);
    chk("wr_we_ack", ram_we_o, 0);
    m0_req_i = 0; m0_we_i = 0;
    tick();
    chk("wr_ack_width", m0_ack_o, 0);
    chk("wr_we_count", we_cnt - we_base, 1);
    m0_req_i = 1;
    tick();
    chk("rd_ack_early", m0_ack_o, 0);
    tick();
    chk("rd_ack", m0_ack_o, 1);
    chk("rd_data", m0_rdata_o, 32'hDEADBEEF);
    m0_req_i = 0;
    tick();

    // Both masters requesting continuously from reset
    rst_n_i = 1'b0;
    #1;
    rst_n_i = 1'b1;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h10;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("rr_m0_ack_%0d", i), m0_ack_o, (i % 6 == 2) ? 1 : 0);
      chk($sformatf("rr_m1_ack_%0d", i), m1_ack_o, (i % 6 == 5) ? 1 : 0);
      if (i % 3 == 1) chk($sformatf("rr_owner_%0d", i), owner_o, (i / 3) % 2);
      if (i == 5) chk("rr_m1_rdata", m1_rdata_o, 32'hDEADBEEF);
    end
    m0_req_i = 0; m1_req_i = 0;

    // M1 writes while M0 waits, then M0 reads the new word
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h20; m1_wdata_i = 32'h11223344;
    tick();
    chk("m1w_owner", owner_o, 1);
    chk("m1w_we", ram_we_o, 1);
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h20;
    tick();
    chk("m1w_ack", m1_ack_o, 1);
    chk("m1w_m0_wait", m0_ack_o, 0);
    m1_req_i = 0; m1_we_i = 0;
    tick(); tick();
    chk("m0r_owner", owner_o, 0);
    chk("m0r_we", ram_we_o, 0);
    tick();
    chk("m0r_ack", m0_ack_o, 1);
    chk("m0r_data", m0_rdata_o, 32'h11223344);
    m0_req_i = 0;
    tick();
    m1_req_i = 1; m1_addr_i = 32'h20;
    tick(); tick();
    chk("m1r_ack", m1_ack_o, 1);
    chk("m1r_data", m1_rdata_o, 32'h11223344);
    m1_req_i = 0;
    tick();

    // M1 pulses its request only while M0 owns the port
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10;
    tick();
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h30; m1_wdata_i = 32'hFFFF0000;
    tick();
    chk("pulse_m0_ack", m0_ack_o, 1);
    chk("pulse_m0_data", m0_rdata_o, 32'hDEADBEEF);
    m1_req_i = 0; m1_we_i = 0; m0_req_i = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("pulse_m1_ack_%0d", i), m1_ack_o, 0);
      chk($sformatf("pulse_busy_%0d", i), busy_o, 0);
    end

    // M0 holds its request through the ack: two back-to-back transactions
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h20;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("b2b_ack_%0d", i), m0_ack_o, (i == 2 || i == 5) ? 1 : 0);
      if (i == 5) begin
        chk("b2b_data", m0_rdata_o, 32'h11223344);
        m0_req_i = 0;
      end
    end
    chk("m1_rdata_hold", m1_rdata_o, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
